// File: rtl/uart_rxd_fifo.sv
// UART receiver (8N1, mid-bit sampling) feeding a circular byte FIFO with a
// registered head output and sticky overrun / framing-error flags.
module uart_rxd_fifo #(
    parameter int CLKDIV     = 208,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rxd,
    input  logic                  rd,
    input  logic                  clr,
    output logic [7:0]            q,
    output logic                  avail,
    output logic [7:0]            status,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int TW    = $clog2(CLKDIV);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [TW-1:0]       HALF_LOAD  = TW'(CLKDIV / 2 - 1);
    localparam logic [TW-1:0]       FULL_LOAD  = TW'(CLKDIV - 1);
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE_COUNT  = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

    logic [1:0]            sync_reg;
    logic                  rs;
    rx_state_t             state_reg, state_next;
    logic [TW-1:0]         timer_reg, timer_next;
    logic [7:0]            shift_reg, shift_next;
    logic [2:0]            bit_reg, bit_next;
    logic                  push_reg, push_next;
    logic                  ferr_set;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_inc;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [7:0]            q_reg;
    logic                  overrun_reg, ferr_reg;
    logic                  do_pop, do_push, overrun_set;

    assign rs = sync_reg[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_reg  <= 2'b11;
            state_reg <= IDLE;
            timer_reg <= '0;
            shift_reg <= '0;
            bit_reg   <= '0;
            push_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], rxd};
            state_reg <= state_next;
            timer_reg <= timer_next;
            shift_reg <= shift_next;
            bit_reg   <= bit_next;
            push_reg  <= push_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = (timer_reg != '0) ? timer_reg - 1'b1 : timer_reg;
        shift_next = shift_reg;
        bit_next   = bit_reg;
        push_next  = 1'b0;
        ferr_set   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rs) begin
                    timer_next = HALF_LOAD;
                    state_next = START;
                end
            end
            START: begin
                if (timer_reg == '0) begin
                    if (rs) begin
                        state_next = IDLE;
                    end else begin
                        timer_next = FULL_LOAD;
                        bit_next   = '0;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (timer_reg == '0) begin
                    shift_next = {rs, shift_reg[7:1]};
                    timer_next = FULL_LOAD;
                    bit_next   = bit_reg + 1'b1;
                    if (bit_reg == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                // shift_reg holds the byte through the push cycle; nothing
                // touches it again until the next frame's first data sample.
                if (timer_reg == '0) begin
                    if (rs) begin
                        push_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign do_pop      = rd && (count_reg != '0);
    assign do_push     = push_reg && ((count_reg != FULL_COUNT) || do_pop);
    assign overrun_set = push_reg && (count_reg == FULL_COUNT) && !do_pop;
    assign rd_ptr_inc  = rd_ptr_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= shift_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            q_reg       <= '0;
            overrun_reg <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_inc;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // The new head is the incoming byte whenever it lands in a slot
            // that becomes the head this same cycle, so bypass the RAM there.
            if (do_pop)
                q_reg <= (do_push && count_reg == ONE_COUNT) ? shift_reg : mem[rd_ptr_inc];
            else if (do_push && count_reg == '0)
                q_reg <= shift_reg;
            overrun_reg <= overrun_set | (overrun_reg & ~clr);
            ferr_reg    <= ferr_set | (ferr_reg & ~clr);
        end
    end

    assign q      = q_reg;
    assign count  = count_reg;
    assign avail  = (count_reg != '0);
    assign status = {5'b0, overrun_reg, ferr_reg, avail};

endmodule

// File: tb/tb_uart_rxd_fifo.sv
// Bench for uart_rxd_fifo: frames are scheduled into a queue-based FIFO model
// at their arithmetic push time; outputs are compared against it every cycle.
module tb_uart_rxd_fifo;

    localparam int CLKDIV = 16;
    localparam int DL     = 3;
    localparam int DEPTH  = 8;
    // Push lands 156 edges after the start bit is driven; stop sample at 155.
    localparam int PUSH_EDGE = 156;
    localparam int STOP_EDGE = 155;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rxd = 1'b1;
    logic          rd = 1'b0;
    logic          clr = 1'b0;
    logic [7:0]    q;
    logic          avail;
    logic [7:0]    status;
    logic [DL:0]   count;

    uart_rxd_fifo #(.CLKDIV(CLKDIV), .DEPTH_LOG2(DL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rxd     (rxd),
        .rd      (rd),
        .clr     (clr),
        .q       (q),
        .avail   (avail),
        .status  (status),
        .count   (count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         cmp_en = 1'b0;
    bit         push_sched [int];
    logic [7:0] push_byte  [int];
    bit         ferr_sched [int];
    logic [7:0] mq [$];
    bit         m_ovr = 1'b0;
    bit         m_ferr = 1'b0;
    bit         m_avail;
    bit         pop_ok, push_now, ovr_set;
    logic [7:0] rb;
    bit         rstop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: one update per rising edge using the inputs seen there.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            mq.delete();
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            pop_ok   = rd && (mq.size() > 0);
            push_now = push_sched.exists(cyc);
            ovr_set  = push_now && (mq.size() == DEPTH) && !pop_ok;
            if (pop_ok) void'(mq.pop_front());
            if (push_now && !ovr_set) mq.push_back(push_byte[cyc]);
            m_ovr  = ovr_set || (m_ovr && !clr);
            m_ferr = ferr_sched.exists(cyc) || (m_ferr && !clr);
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            m_avail = (mq.size() != 0);
            chk("avail", avail, m_avail);
            chk("count", count, mq.size());
            chk("status", status, {5'b0, m_ovr, m_ferr, m_avail});
            if (m_avail) chk("q", q, mq[0]);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic idle(input int n, input int rd_pct, input int clr_pct);
        rxd = 1'b1;
        for (int i = 0; i < n; i++) begin
            rd  = ($urandom_range(0, 99) < rd_pct);
            clr = ($urandom_range(0, 99) < clr_pct);
            tick(1);
        end
        rd  = 1'b0;
        clr = 1'b0;
    endtask

    // Drives one 160-clock frame; leaves rxd at the stop-bit level.
    // rd_t: tick index at which rd is forced high; abort_t: tick at which
    // reset is pulsed for 3 clocks and the frame is abandoned.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int rd_t,
                              input int abort_t, input int rd_pct, input int clr_pct);
        int k;
        int j;
        k = cyc;
        if (abort_t < 0) begin
            if (stop) begin
                push_sched[k + PUSH_EDGE] = 1'b1;
                push_byte[k + PUSH_EDGE]  = b;
            end else begin
                ferr_sched[k + STOP_EDGE] = 1'b1;
            end
        end
        for (int t = 0; t < 160; t++) begin
            if (t == abort_t) begin
                reset_n = 1'b0;
                rxd     = 1'b1;
                rd      = 1'b0;
                clr     = 1'b0;
                tick(3);
                reset_n = 1'b1;
                return;
            end
            j = t / 16;
            rxd = (j == 0) ? 1'b0 : (j == 9) ? stop : b[j-1];
            rd  = (t == rd_t) || ($urandom_range(0, 99) < rd_pct);
            clr = ($urandom_range(0, 99) < clr_pct);
            tick(1);
        end
        rd  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic nine_test(input logic [7:0] base);
        for (int i = 0; i < 9; i++) send_frame(base + 8'(i), 1'b1, -1, -1, 0, 0);
        chk("nine_count", count, 8);
        chk("nine_status", status, 8'h05);
        for (int i = 0; i < 8; i++) begin
            chk("nine_q", q, base + 8'(i));
            pulse_rd();
        end
        chk("nine_empty", count, 0);
        pulse_clr();
        chk("nine_clr_status", status, 8'h00);
    endtask

    initial begin
        tick(4);
        chk("reset_q", q, 8'h00);
        chk("reset_avail", avail, 1'b0);
        chk("reset_count", count, 0);
        chk("reset_status", status, 8'h00);
        cmp_en  = 1'b1;
        reset_n = 1'b1;
        tick(4);

        // Single frame then pop.
        send_frame(8'hA5, 1'b1, -1, -1, 0, 0);
        chk("a5_q", q, 8'hA5);
        chk("a5_count", count, 1);
        chk("a5_status", status, 8'h01);
        pulse_rd();
        chk("a5_avail_after_rd", avail, 1'b0);
        chk("a5_count_after_rd", count, 0);

        // Short glitch; a frame 8 clocks after it must be received intact.
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(8);
        chk("glitch_status", status, 8'h00);
        chk("glitch_count", count, 0);
        send_frame(8'h3A, 1'b1, -1, -1, 0, 0);
        chk("post_glitch_q", q, 8'h3A);
        pulse_rd();

        // Overrun, then wrap-around after advancing the pointers by 5.
        nine_test(8'h00);
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h50 + 8'(i), 1'b1, -1, -1, 0, 0);
            pulse_rd();
        end
        nine_test(8'h10);

        // Framing error followed by a held-low line.
        send_frame(8'h3C, 1'b0, -1, -1, 0, 0);
        tick(40);
        rxd = 1'b1;
        tick(4);
        chk("ferr_status", status, 8'h02);
        chk("ferr_count", count, 0);
        pulse_clr();
        chk("ferr_clr_status", status, 8'h00);

        // Push into a full FIFO with a simultaneous pop.
        for (int i = 0; i < 8; i++) send_frame(8'h60 + 8'(i), 1'b1, -1, -1, 0, 0);
        chk("full_count", count, 8);
        send_frame(8'h77, 1'b1, PUSH_EDGE - 1, -1, 0, 0);
        chk("full_rdpush_count", count, 8);
        chk("full_rdpush_status", status, 8'h01);
        for (int i = 1; i < 8; i++) begin
            chk("full_drain_q", q, 8'h60 + 8'(i));
            pulse_rd();
        end
        chk("full_last_q", q, 8'h77);
        pulse_rd();

        // Reset during data bit 4, then a clean frame.
        send_frame(8'h5A, 1'b1, -1, -1, 0, 0);
        send_frame(8'hC3, 1'b1, -1, 85, 0, 0);
        chk("midreset_q", q, 8'h00);
        chk("midreset_avail", avail, 1'b0);
        chk("midreset_count", count, 0);
        chk("midreset_status", status, 8'h00);
        tick(4);
        send_frame(8'h81, 1'b1, -1, -1, 0, 0);
        chk("after_reset_q", q, 8'h81);
        chk("after_reset_count", count, 1);
        pulse_rd();

        // Randomized traffic with stray pops, clears and bad stop bits.
        pulse_clr();
        for (int n = 0; n < 30; n++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 9) != 0);
            send_frame(rb, rstop, -1, -1, 6, 2);
            if (!rstop) tick($urandom_range(1, 20));
            idle($urandom_range(2, 30), 6, 2);
        end
        idle(10, 0, 0);
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
